// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population count, CHUNK bits per clock, valid/ready on both sides.
// Build option: define POPCOUNT_EARLY_EXIT_EN to finish as soon as the remaining shifted bits are all zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new word; IN_READY high
// RUN   | counting one CHUNK of the shift register per clock
// DONE  | OUT_COUNT/OUT_ALL/OUT_NONE valid, held until OUT_READY
module popcount_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [WIDTH-1:0]           IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [$clog2(WIDTH+1)-1:0] OUT_COUNT,
  output logic                       OUT_ALL,
  output logic                       OUT_NONE,
  output logic                       BUSY
);

  localparam int CW    = $clog2(WIDTH + 1);
  localparam int BEATS = WIDTH / CHUNK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL      = CW'(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("popcount_seq: WIDTH must be at least 2");
  end
  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("popcount_seq: CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    acc_q;
  logic [CW-1:0]    sum;
  logic [BW-1:0]    beat_q;
  logic             finish;

  function automatic logic [CW-1:0] chunk_pop(input logic [CHUNK-1:0] bits);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = n + CW'(bits[i]);
    end
    return n;
  endfunction

  // With a single chunk the whole word is consumed in one beat, so nothing shifts in.
  if (CHUNK == WIDTH) begin : g_single_chunk
    assign shift_nxt = '0;
  end else begin : g_multi_chunk
    assign shift_nxt = {{CHUNK{1'b0}}, shift_q[WIDTH-1:CHUNK]};
  end

  assign sum = acc_q + chunk_pop(shift_q[CHUNK-1:0]);

`ifdef POPCOUNT_EARLY_EXIT_EN
  assign finish = (beat_q == LAST_BEAT) || (shift_nxt == '0);
`else
  assign finish = (beat_q == LAST_BEAT);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (finish) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        BUSY      = 1'b1;
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q   <= '0;
      acc_q     <= '0;
      beat_q    <= '0;
      OUT_COUNT <= '0;
      OUT_ALL   <= 1'b0;
      OUT_NONE  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IN_VALID) begin
            shift_q <= IN_DATA;
            acc_q   <= '0;
            beat_q  <= '0;
          end
        end
        S_RUN: begin
          shift_q <= shift_nxt;
          acc_q   <= sum;
          beat_q  <= beat_q + 1'b1;
          if (finish) begin
            OUT_COUNT <= sum;
            OUT_ALL   <= (sum == FULL);
            OUT_NONE  <= (sum == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
